// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the yIF/yID/yEX/yDM/yWB/yPC datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB with registered Moore outputs.
module mc_ctrl #(
    parameter int CNT_W       = 32,
    parameter int BOOT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             int_req,
    input  logic             dm_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             Mem2Reg,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [2:0]       op,
    output logic             branch,
    output logic             jump,
    output logic             INT,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_J} cls_e;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem2reg;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] op;
        logic       branch;
        logic       jump;
        logic       int_sel;
    } ctrl_t;

    localparam logic [2:0] BOOT_LAST = 3'(BOOT_CYCLES - 1);
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b110;

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    logic [2:0]       rop_q, rop_d;
    logic [2:0]       boot_cnt_q, boot_cnt_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q;
    ctrl_t            ctrl_q;

    cls_e       dec_cls;
    logic [2:0] dec_op;
    logic       dec_ok;
    logic       sw_done;
    logic       retire;
    state_e     ret_state;

    // yPC consumes zero directly; the sequencer itself never branches on it.
    logic unused_zero;
    assign unused_zero = zero;

    // Control word for a given state; every field not listed stays 0.
    function automatic ctrl_t ctrl_for(input state_e s, input cls_e c, input logic [2:0] rop);
        ctrl_t k;
        k = '0;
        case (s)
            S_BOOT: begin
                k.int_sel = 1'b1;
                k.pc_we   = 1'b1;
                k.alu_src = 1'b1;
                k.op      = OP_ADD;
            end
            S_FETCH: k.ir_we = 1'b1;
            S_EXEC: begin
                case (c)
                    C_R: begin
                        k.reg_dst = 1'b1;
                        k.op      = rop;
                    end
                    C_BEQ: begin
                        k.op     = OP_SUB;
                        k.branch = 1'b1;
                        k.pc_we  = 1'b1;
                    end
                    C_J: begin
                        k.jump  = 1'b1;
                        k.pc_we = 1'b1;
                    end
                    default: begin
                        k.alu_src = 1'b1;
                        k.op      = OP_ADD;
                    end
                endcase
            end
            S_MEM: begin
                k.alu_src   = 1'b1;
                k.op        = OP_ADD;
                k.mem_read  = (c == C_LW);
                k.mem_write = (c == C_SW);
            end
            S_WB: begin
                k.reg_write = 1'b1;
                k.pc_we     = 1'b1;
                if (c == C_R) begin
                    k.reg_dst = 1'b1;
                    k.op      = rop;
                end else begin
                    k.alu_src = 1'b1;
                    k.op      = OP_ADD;
                    k.mem2reg = (c == C_LW);
                end
            end
            default: k = '0;
        endcase
        return k;
    endfunction

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
        dec_cls = C_R;
        dec_op  = OP_ADD;
        dec_ok  = 1'b1;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20:   dec_op = 3'b010;
                    6'h22:   dec_op = 3'b110;
                    6'h24:   dec_op = 3'b000;
                    6'h25:   dec_op = 3'b001;
                    6'h2a:   dec_op = 3'b111;
                    default: dec_ok = 1'b0;
                endcase
            end
            6'h08:   dec_cls = C_ADDI;
            6'h23:   dec_cls = C_LW;
            6'h2b:   dec_cls = C_SW;
            6'h04:   dec_cls = C_BEQ;
            6'h02:   dec_cls = C_J;
            default: dec_ok  = 1'b0;
        endcase
    end

    // A store completes in the same cycle memory reports ready, so its PC load follows dm_ready.
    assign sw_done   = (state_q == S_MEM) && (cls_q == C_SW) && dm_ready;
    assign pc_we     = ctrl_q.pc_we | sw_done;
    assign retire    = pc_we && (state_q != S_BOOT);
    assign ret_state = int_req ? S_BOOT : S_FETCH;

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        rop_d      = rop_q;
        illegal_d  = illegal_q;
        boot_cnt_d = 3'd0;
        case (state_q)
            S_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) state_d = S_FETCH;
                else                         boot_cnt_d = boot_cnt_q + 3'd1;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (dec_ok) begin
                    cls_d   = dec_cls;
                    rop_d   = dec_op;
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_R, C_ADDI: state_d = S_WB;
                    C_LW, C_SW:  state_d = S_MEM;
                    default:     state_d = ret_state;
                endcase
            end
            S_MEM: begin
                if (dm_ready) state_d = (cls_q == C_LW) ? S_WB : ret_state;
            end
            S_WB:    state_d = ret_state;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            cls_q      <= C_R;
            rop_q      <= OP_ADD;
            boot_cnt_q <= 3'd0;
            illegal_q  <= 1'b0;
            retired_q  <= '0;
            ctrl_q     <= ctrl_for(S_BOOT, C_R, OP_ADD);
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            rop_q      <= rop_d;
            boot_cnt_q <= boot_cnt_d;
            illegal_q  <= illegal_d;
            ctrl_q     <= ctrl_for(state_d, cls_d, rop_d);
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign ir_we    = ctrl_q.ir_we;
    assign RegDst   = ctrl_q.reg_dst;
    assign RegWrite = ctrl_q.reg_write;
    assign ALUSrc   = ctrl_q.alu_src;
    assign Mem2Reg  = ctrl_q.mem2reg;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign op       = ctrl_q.op;
    assign branch   = ctrl_q.branch;
    assign jump     = ctrl_q.jump;
    assign INT      = ctrl_q.int_sel;
    assign state    = state_q;
    assign retired  = retired_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected control vectors are queued, then popped and compared.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        zero = 1'b0;
    logic        int_req = 1'b0;
    logic        dm_ready = 1'b0;
    logic        ir_we, pc_we, RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite;
    logic [2:0]  op;
    logic        branch, jump, INT;
    logic [2:0]  state;
    logic [31:0] retired;
    logic        illegal;

    mc_ctrl #(.CNT_W(32), .BOOT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .int_req(int_req), .dm_ready(dm_ready), .ir_we(ir_we), .pc_we(pc_we),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg),
        .MemRead(MemRead), .MemWrite(MemWrite), .op(op), .branch(branch), .jump(jump),
        .INT(INT), .state(state), .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef logic [17:0] obs_t;
    obs_t  obs;
    obs_t  exp_q[$];
    string tag;
    int    n_vec = 0;
    int    n_fail = 0;

    assign obs = {state, ir_we, pc_we, RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite,
                  op, branch, jump, INT, illegal};

    function automatic obs_t mk(input logic [2:0] st, input logic irw, pcw, rdst, rw, asrc,
                                m2r, mr, mw, input logic [2:0] aop, input logic br, jmp, intr, ill);
        return {st, irw, pcw, rdst, rw, asrc, m2r, mr, mw, aop, br, jmp, intr, ill};
    endfunction

    function automatic obs_t boot_v();   return mk(3'd0, 0,1,0,0,1,0,0,0, 3'b010, 0,0,1,0); endfunction
    function automatic obs_t fetch_v();  return mk(3'd1, 1,0,0,0,0,0,0,0, 3'b000, 0,0,0,0); endfunction
    function automatic obs_t decode_v(); return mk(3'd2, 0,0,0,0,0,0,0,0, 3'b000, 0,0,0,0); endfunction
    function automatic obs_t iexec_v();  return mk(3'd3, 0,0,0,0,1,0,0,0, 3'b010, 0,0,0,0); endfunction
    function automatic obs_t halt_v();   return mk(3'd6, 0,0,0,0,0,0,0,0, 3'b000, 0,0,0,1); endfunction

    task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // One clock: compare the popped expectation at the falling edge, then step to just past the rising edge.
    task automatic cycle();
        obs_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty", tag);
            $fatal(1, "scoreboard underrun");
        end
        e = exp_q.pop_front();
        check(tag, 64'(obs), 64'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_ins(input logic [5:0] opc, input logic [5:0] fn);
        opcode = opc;
        funct  = fn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Held in reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_vec", 64'(obs), 64'(boot_v()));
        check("reset_retired", 64'(retired), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        tag = "boot";
        exp_q.push_back(boot_v());
        run(1);

        // R-type or
        tag = "r_or";
        set_ins(6'h00, 6'h25);
        exp_q.push_back(fetch_v());
        exp_q.push_back(decode_v());
        exp_q.push_back(mk(3'd3, 0,0,1,0,0,0,0,0, 3'b001, 0,0,0,0));
        exp_q.push_back(mk(3'd5, 0,1,1,1,0,0,0,0, 3'b001, 0,0,0,0));
        run(4);
        check("r_or_retired", 64'(retired), 64'd1);

        // lw with three wait states
        tag = "lw";
        set_ins(6'h23, 6'h00);
        dm_ready = 1'b0;
        exp_q.push_back(fetch_v());
        exp_q.push_back(decode_v());
        exp_q.push_back(iexec_v());
        repeat (4) exp_q.push_back(mk(3'd4, 0,0,0,0,1,0,1,0, 3'b010, 0,0,0,0));
        exp_q.push_back(mk(3'd5, 0,1,0,1,1,1,0,0, 3'b010, 0,0,0,0));
        run(6);
        dm_ready = 1'b1;
        run(1);
        dm_ready = 1'b0;
        run(1);
        check("lw_retired", 64'(retired), 64'd2);

        // sw with memory ready at once: PC load in the MEM cycle
        tag = "sw";
        set_ins(6'h2b, 6'h00);
        dm_ready = 1'b1;
        exp_q.push_back(fetch_v());
        exp_q.push_back(decode_v());
        exp_q.push_back(iexec_v());
        exp_q.push_back(mk(3'd4, 0,1,0,0,1,0,0,1, 3'b010, 0,0,0,0));
        run(4);
        dm_ready = 1'b0;
        check("sw_retired", 64'(retired), 64'd3);

        // beq taken and not taken produce identical control
        for (int z = 1; z >= 0; z--) begin
            tag = (z == 1) ? "beq_z1" : "beq_z0";
            zero = z[0];
            set_ins(6'h04, 6'h00);
            exp_q.push_back(fetch_v());
            exp_q.push_back(decode_v());
            exp_q.push_back(mk(3'd3, 0,1,0,0,0,0,0,0, 3'b110, 1,0,0,0));
            run(3);
        end
        check("beq_retired", 64'(retired), 64'd5);

        tag = "j";
        set_ins(6'h02, 6'h00);
        exp_q.push_back(fetch_v());
        exp_q.push_back(decode_v());
        exp_q.push_back(mk(3'd3, 0,1,0,0,0,0,0,1, 3'b000, 0,1,0,0) ^ mk(3'd0, 0,0,0,0,0,0,0,1, 3'b000, 0,0,0,0));
        run(3);
        check("j_retired", 64'(retired), 64'd6);

        // addi with int_req raised early; only the retire cycle honours it
        tag = "addi_int";
        set_ins(6'h08, 6'h00);
        exp_q.push_back(fetch_v());
        exp_q.push_back(decode_v());
        exp_q.push_back(iexec_v());
        exp_q.push_back(mk(3'd5, 0,1,0,1,1,0,0,0, 3'b010, 0,0,0,0));
        exp_q.push_back(boot_v());
        run(1);
        int_req = 1'b1;
        run(3);
        int_req = 1'b0;
        run(1);
        check("int_retired", 64'(retired), 64'd7);

        // Illegal opcode halts; interrupts ignored while halted
        tag = "illegal_op";
        set_ins(6'h3f, 6'h00);
        exp_q.push_back(fetch_v());
        exp_q.push_back(decode_v());
        repeat (4) exp_q.push_back(halt_v());
        run(2);
        int_req = 1'b1;
        run(4);
        int_req = 1'b0;
        check("halt_retired", 64'(retired), 64'd7);

        // Asynchronous reset leaves HALT
        #2 rst_n = 1'b0;
        #1;
        check("halt_rst_vec", 64'(obs), 64'(boot_v()));
        check("halt_rst_retired", 64'(retired), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        tag = "illegal_funct";
        set_ins(6'h00, 6'h21);
        exp_q.push_back(boot_v());
        exp_q.push_back(fetch_v());
        exp_q.push_back(decode_v());
        exp_q.push_back(halt_v());
        run(4);

        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of a stalled store drops MemWrite at once
        tag = "sw_abort";
        set_ins(6'h2b, 6'h00);
        dm_ready = 1'b0;
        exp_q.push_back(boot_v());
        exp_q.push_back(fetch_v());
        exp_q.push_back(decode_v());
        exp_q.push_back(iexec_v());
        repeat (2) exp_q.push_back(mk(3'd4, 0,0,0,0,1,0,0,1, 3'b010, 0,0,0,0));
        run(6);
        rst_n = 1'b0;
        #1;
        check("sw_abort_memwrite", 64'(MemWrite), 64'd0);
        check("sw_abort_state", 64'(state), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
